// File: rtl/brake_ctrl_moore_fsm.sv
// Brake control Moore FSM: z asserts after HOLD_CYCLES consecutive w=1 edges.
// State, counter and z are all registered; no path from w to y or z.
module brake_ctrl_moore_fsm #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       w,
    output logic [2:1] y,
    output logic       z
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COUNT   = 2'b01,
        ACTIVE  = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_z;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + ONE;

    // resetn is active-high despite its name
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_z     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w) begin
                        if (HOLD_CYCLES == 1) begin
                            r_state <= ACTIVE;
                            r_cnt   <= HOLD;
                            r_z     <= 1'b1;
                        end else begin
                            r_state <= COUNT;
                            r_cnt   <= ONE;
                            r_z     <= 1'b0;
                        end
                    end else begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_z     <= 1'b0;
                    end
                end
                COUNT: begin
                    if (!w) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_z     <= 1'b0;
                    end else if (w_cnt_inc == HOLD) begin
                        r_state <= ACTIVE;
                        r_cnt   <= HOLD;
                        r_z     <= 1'b1;
                    end else begin
                        r_state <= COUNT;
                        r_cnt   <= w_cnt_inc;
                        r_z     <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (!w) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_z     <= 1'b0;
                    end else begin
                        r_state <= ACTIVE;
                        r_z     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_z     <= 1'b0;
                end
            endcase
        end
    end

    assign y = r_state;
    assign z = r_z;

endmodule

// File: tb/tb_brake_ctrl_moore_fsm.sv
// Directed bench for brake_ctrl_moore_fsm with HOLD_CYCLES=2 and =1.
// Checks {y,z} one time unit after each rising edge.
module tb_brake_ctrl_moore_fsm;

    logic       clk = 1'b0;
    logic       resetn;
    logic       w;
    logic [2:1] ya;
    logic       za;
    logic [2:1] yb;
    logic       zb;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    brake_ctrl_moore_fsm #(.HOLD_CYCLES(2), .CNT_W(8)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .w      (w),
        .y      (ya),
        .z      (za)
    );

    brake_ctrl_moore_fsm #(.HOLD_CYCLES(1), .CNT_W(8)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .w      (w),
        .y      (yb),
        .z      (zb)
    );

    task automatic chk(input string tag, input logic [2:0] got,
                       input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {y,z}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic wv);
        @(negedge clk);
        resetn = rst;
        w      = wv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b1;
        w      = 1'b1;

        // reset held with w=1
        cyc(1'b1, 1'b1);
        chk("rst_e1", {ya, za}, 3'b000);
        chk("rst_e1_b", {yb, zb}, 3'b000);
        cyc(1'b1, 1'b1);
        chk("rst_e2", {ya, za}, 3'b000);
        cyc(1'b0, 1'b1);
        chk("rel_count", {ya, za}, 3'b010);
        cyc(1'b0, 1'b1);
        chk("rel_active", {ya, za}, 3'b101);
        cyc(1'b0, 1'b0);
        chk("rel_idle", {ya, za}, 3'b000);

        // glitch between edges
        cyc(1'b0, 1'b0);
        chk("pre_glitch", {ya, za}, 3'b000);
        #2 w = 1'b1;
        #6 w = 1'b0;
        @(posedge clk);
        #1;
        chk("glitch", {ya, za}, 3'b000);

        // short run of one edge
        cyc(1'b0, 1'b1);
        chk("short_cnt", {ya, za}, 3'b010);
        cyc(1'b0, 1'b0);
        chk("short_idle", {ya, za}, 3'b000);

        // threshold run n..n+3 then drop
        cyc(1'b0, 1'b1);
        chk("thr_n", {ya, za}, 3'b010);
        cyc(1'b0, 1'b1);
        chk("thr_n1", {ya, za}, 3'b101);
        cyc(1'b0, 1'b1);
        chk("thr_n2", {ya, za}, 3'b101);
        cyc(1'b0, 1'b1);
        chk("thr_n3", {ya, za}, 3'b101);
        cyc(1'b0, 1'b0);
        chk("thr_n4", {ya, za}, 3'b000);

        // reset while active
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("mid_active", {ya, za}, 3'b101);
        cyc(1'b1, 1'b1);
        chk("mid_rst", {ya, za}, 3'b000);
        cyc(1'b0, 1'b1);
        chk("mid_rel1", {ya, za}, 3'b010);
        cyc(1'b0, 1'b1);
        chk("mid_rel2", {ya, za}, 3'b101);

        // HOLD_CYCLES=1 instance
        cyc(1'b1, 1'b0);
        chk("h1_rst", {yb, zb}, 3'b000);
        cyc(1'b0, 1'b1);
        chk("h1_active", {yb, zb}, 3'b101);
        chk("h1_a_count", {ya, za}, 3'b010);
        cyc(1'b0, 1'b1);
        chk("h1_hold", {yb, zb}, 3'b101);
        cyc(1'b0, 1'b0);
        chk("h1_idle", {yb, zb}, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/brake_ctrl_moore_fsm.md
Name: brake_ctrl_moore_fsm

Overview:
- Moore state machine for brake control: asserts output z once sensor input w has been sampled high on HOLD_CYCLES consecutive rising clock edges.
- z stays high while w stays high and drops one edge after w is sampled low.
- Current state code y is exported for debug.
- Sits between a synchronised sensor line and the brake actuator logic.

Parameters:
- HOLD_CYCLES, 2, number of consecutive edges with w=1 required before z asserts; legal range 1..255.
- CNT_W, 8, width of the internal run-length counter; must satisfy 2**CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- resetn  input  1  synchronous reset, active-high despite the name: resetn=1 at a rising edge forces reset.
- w  input  1  sensor input, already synchronous to clk; sampled on each rising edge.
- y  output  2 ([2:1])  registered current-state code.
- z  output  1  brake-active output; Moore (function of state only).

Behaviour:
- One clock; reset is synchronous and active-high. No other asynchronous paths.
- States and codes on y:
  - IDLE = 2'b00: no run of w=1.
  - COUNT = 2'b01: run started, fewer than HOLD_CYCLES edges with w=1.
  - ACTIVE = 2'b10: run of at least HOLD_CYCLES edges.
  - 2'b11 is illegal.
- Internal counter cnt (CNT_W bits) counts consecutive edges at which w was sampled 1. It is cleared in IDLE and saturates at HOLD_CYCLES.
- Reset: resetn=1 at a rising edge sets state=IDLE, cnt=0, z=0, y=00 after that edge, irrespective of w. Reset has priority over every transition.
- Transitions, evaluated at each rising edge with resetn=0:
  - IDLE, w=0 -> IDLE.
  - IDLE, w=1 -> ACTIVE if HOLD_CYCLES=1, else COUNT with cnt=1.
  - COUNT, w=0 -> IDLE, cnt=0.
  - COUNT, w=1, cnt+1 == HOLD_CYCLES -> ACTIVE, cnt=HOLD_CYCLES.
  - COUNT, w=1 otherwise -> COUNT, cnt+1.
  - ACTIVE, w=1 -> ACTIVE (cnt holds).
  - ACTIVE, w=0 -> IDLE, cnt=0.
  - Illegal code 11 -> IDLE on the next edge; z=0 while in 11.
- Output: z=1 exactly when state==ACTIVE. z is registered with the state; no combinational path from w to z or y.
- Latency (HOLD_CYCLES=2): z rises after the 2nd consecutive edge sampling w=1 and falls after the first edge sampling w=0.
- A pulse on w shorter than one clock period that is not present at any rising edge has no effect.
- A run of w=1 shorter than HOLD_CYCLES edges returns to IDLE with z never asserting.
- Reset mid-run (in COUNT or ACTIVE): next edge gives IDLE, z=0. After release, the count restarts from zero.

Test Plan:
- Reset: hold resetn=1 for 2 edges with w=1 -> y=00, z=0 throughout; release -> first edge with w=1 gives y=01.
- Sub-cycle glitch: w=1 for 6 time units between edges (period 10) -> y stays 00, z stays 0.
- Short run: w=1 sampled at exactly 1 edge, then 0 -> y 00->01->00, z never 1.
- Threshold run: w=1 at edges n, n+1, n+2, n+3, then 0 at n+4 -> y=01 after n, 10 after n+1..n+3, 00 after n+4; z=1 from after n+1 until after n+4.
- Reset mid-ACTIVE: in y=10 with w=1, assert resetn for one edge -> y=00, z=0; release with w=1 -> y=01 then 10, a full 2-edge latency again.
- Parameter HOLD_CYCLES=1: w=1 at one edge -> y=10, z=1 directly from IDLE; w=0 at next edge -> y=00, z=0.
